// File: rtl/sipo_shift_receiver_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver and its
// parallel-load shift-right transmitter counterpart.
//   - state_t       : receiver FSM states (RECV, PARITY)
//   - DEFAULT_WIDTH : word width shared by transmitter and receiver
//   - PARITY_POL    : parity polarity, 0 = even parity over data + parity bit
package sipo_shift_receiver_pkg;

    localparam logic [0:0] ST_RECV   = 1'b0;
    localparam logic [0:0] ST_PARITY = 1'b1;

    typedef enum logic [0:0] {
        RECV   = ST_RECV,
        PARITY = ST_PARITY
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic PARITY_POL = 1'b0;

endpackage

// File: rtl/sipo_shift_receiver.sv
// Serial-in, parallel-out receiver. Collects WIDTH qualified serial bits
// (LSB first) and presents the reassembled word on q with a one-cycle
// q_valid strobe. Optional trailing even-parity bit when the macro
// SIPO_PARITY_EN is defined; otherwise parity_err is tied 0.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   shift_en   : serial_in qualifier
//   serial_in  : serial data, LSB first
//   clear      : synchronous abort of a partial word (beats shift_en)
//   q          : last completed word, held until the next completion
//   q_valid    : one-cycle pulse when q updates
//   busy       : partial word in progress
//   bit_cnt    : data bits received in the current word
//   parity_err : parity mismatch, valid with q_valid
module sipo_shift_receiver
    import sipo_shift_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             parity_err
);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic             last_bit;

    // New bit enters the MSB so the first-received bit ends at the LSB.
    assign shift_nxt = {serial_in, shift_reg[WIDTH-1:1]};
    assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy      = (bit_cnt != '0) || (state == PARITY);

`ifndef SIPO_PARITY_EN
    assign state      = RECV;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
            bit_cnt   <= '0;
`ifdef SIPO_PARITY_EN
            state      <= RECV;
            parity_err <= 1'b0;
`endif
        end else begin
            q_valid <= 1'b0;
            if (clear) begin
                bit_cnt <= '0;
`ifdef SIPO_PARITY_EN
                state <= RECV;
`endif
            end else if (shift_en) begin
`ifdef SIPO_PARITY_EN
                if (state == PARITY) begin
                    // shift_reg still holds the complete data word here.
                    q          <= shift_reg;
                    q_valid    <= 1'b1;
                    parity_err <= (^shift_reg) ^ serial_in ^ PARITY_POL;
                    state      <= RECV;
                end else begin
                    shift_reg <= shift_nxt;
                    if (last_bit) begin
                        bit_cnt <= '0;
                        state   <= PARITY;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
`else
                shift_reg <= shift_nxt;
                if (last_bit) begin
                    q       <= shift_nxt;
                    q_valid <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

endmodule
